// File: rtl/router_in_arb_if.sv
// Handshake bundle between three packet sources, the input arbiter and the router input port.
`timescale 1ns/1ps
interface router_in_arb_if;
    logic       src_valid_0;
    logic       src_valid_1;
    logic       src_valid_2;
    logic [7:0] src_data_0;
    logic [7:0] src_data_1;
    logic [7:0] src_data_2;
    logic       src_ready_0;
    logic       src_ready_1;
    logic       src_ready_2;
    logic       grant_0;
    logic       grant_1;
    logic       grant_2;
    logic       busy;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       arb_len_err;

    modport slave (
        input  src_valid_0, src_valid_1, src_valid_2,
        input  src_data_0, src_data_1, src_data_2,
        input  busy,
        output src_ready_0, src_ready_1, src_ready_2,
        output grant_0, grant_1, grant_2,
        output data_in, pkt_valid, arb_len_err
    );

    modport master (
        output src_valid_0, src_valid_1, src_valid_2,
        output src_data_0, src_data_1, src_data_2,
        output busy,
        input  src_ready_0, src_ready_1, src_ready_2,
        input  grant_0, grant_1, grant_2,
        input  data_in, pkt_valid, arb_len_err
    );
endinterface

// File: rtl/router_in_arb.sv
// Round-robin packet arbiter, 3 sources -> 1 router input; length check under ROUTER_ARB_LEN_CHECK_EN.
// Latency: grant registered one edge after request; data path is a combinational mux while granted.
// Backpressure: busy stalls the granted source (src_ready low); other sources wait, never dropped.
`timescale 1ns/1ps
module router_in_arb (
    input  logic            clock,
    input  logic            resetn,
    router_in_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PASS, GAP} state_t;

    state_t     state;
    logic [2:0] grant;
    logic [1:0] ptr;
    logic [2:0] req;
    logic [2:0] pick;
    logic [1:0] next_ptr;
    logic [7:0] sel_data;
    logic       sel_valid;
    logic       in_pass;
    logic       xfer;

    assign req     = {bus.src_valid_2, bus.src_valid_1, bus.src_valid_0};
    assign in_pass = (state == PASS);
    assign xfer    = in_pass && !bus.busy;

    // First requester at or after ptr, wrapping mod 3.
    always_comb begin
        pick = 3'b000;
        case (ptr)
            2'd1: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            2'd2: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

    always_comb begin
        next_ptr = 2'd0;
        if (grant[0])      next_ptr = 2'd1;
        else if (grant[1]) next_ptr = 2'd2;
    end

    always_comb begin
        sel_data  = 8'h00;
        sel_valid = 1'b0;
        if (grant[0]) begin
            sel_data  = bus.src_data_0;
            sel_valid = bus.src_valid_0;
        end else if (grant[1]) begin
            sel_data  = bus.src_data_1;
            sel_valid = bus.src_valid_1;
        end else if (grant[2]) begin
            sel_data  = bus.src_data_2;
            sel_valid = bus.src_valid_2;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= 3'b000;
            ptr   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= pick;
                        state <= PASS;
                    end
                end
                PASS: begin
                    // A transfer with valid low is the parity byte: packet done.
                    if (xfer && !sel_valid) begin
                        grant <= 3'b000;
                        ptr   <= next_ptr;
                        state <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_0     = grant[0];
    assign bus.grant_1     = grant[1];
    assign bus.grant_2     = grant[2];
    assign bus.src_ready_0 = xfer && grant[0];
    assign bus.src_ready_1 = xfer && grant[1];
    assign bus.src_ready_2 = xfer && grant[2];
    assign bus.data_in     = in_pass ? sel_data : 8'h00;
    assign bus.pkt_valid   = in_pass && sel_valid;

`ifdef ROUTER_ARB_LEN_CHECK_EN
    logic [5:0] xfer_cnt;
    logic [5:0] hdr_len;
    logic       len_err;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            xfer_cnt <= 6'd0;
            hdr_len  <= 6'd0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (state == IDLE && (|req)) begin
                xfer_cnt <= 6'd0;
                hdr_len  <= 6'd0;
            end else if (xfer) begin
                if (sel_valid) begin
                    if (xfer_cnt == 6'd0)
                        hdr_len <= sel_data[7:2];
                    if (xfer_cnt != 6'd63)
                        xfer_cnt <= xfer_cnt + 6'd1;
                end else begin
                    // Header plus hdr_len payload bytes must precede parity.
                    len_err <= ({1'b0, xfer_cnt} != ({1'b0, hdr_len} + 7'd1));
                end
            end
        end
    end

    assign bus.arb_len_err = len_err;
`else
    assign bus.arb_len_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_in_arb.sv
// Bench for router_in_arb: per-source byte queues feed the DUT, a scoreboard holds expected router bytes in grant order.
`timescale 1ns/1ps
module tb_router_in_arb;
    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    router_in_arb_if bus ();
    router_in_arb dut (.clock(clock), .resetn(resetn), .bus(bus.slave));

`ifdef ROUTER_ARB_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    typedef struct packed { logic v; logic [7:0] d; } beat_t;
    typedef struct packed { logic [1:0] s; logic v; logic [7:0] d; logic e; } exp_t;
    typedef struct {
        int s; logic [7:0] hdr; int npay; logic [7:0] pbase; logic [7:0] par;
        int b_at; int b_len; int exp_err; int exp_stall;
    } vec_t;

    beat_t sq0[$], sq1[$], sq2[$];
    exp_t  exp_q[$];
    int    gap_log[$];
    int    checks = 0, errors = 0;
    bit    err_pend_vld = 0;
    logic  err_pend = 1'b0;
    bit    after_parity = 0;
    int    gap_run = 0, stall_cnt = 0, err_seen = 0;
    int    busy_at = 0, busy_len = 0, cur_xfers = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_beat(input int s, input beat_t b);
        case (s)
            0:       sq0.push_back(b);
            1:       sq1.push_back(b);
            default: sq2.push_back(b);
        endcase
    endtask

    function automatic beat_t head(input int s);
        beat_t h = '0;
        case (s)
            0:       if (sq0.size() > 0) h = sq0[0];
            1:       if (sq1.size() > 0) h = sq1[0];
            default: if (sq2.size() > 0) h = sq2[0];
        endcase
        return h;
    endfunction

    task automatic pop_beat(input int s);
        case (s)
            0:       if (sq0.size() > 0) void'(sq0.pop_front());
            1:       if (sq1.size() > 0) void'(sq1.pop_front());
            default: if (sq2.size() > 0) void'(sq2.pop_front());
        endcase
    endtask

    // Queue a packet on source s and its expected router-side image on the scoreboard.
    task automatic load_pkt(input int s, input logic [7:0] hdr, input int npay,
                            input logic [7:0] pbase, input logic [7:0] par);
        logic [7:0] d;
        logic       e;
        push_beat(s, {1'b1, hdr});
        exp_q.push_back({2'(s), 1'b1, hdr, 1'b0});
        for (int i = 0; i < npay; i++) begin
            d = pbase + 8'(i);
            push_beat(s, {1'b1, d});
            exp_q.push_back({2'(s), 1'b1, d, 1'b0});
        end
        e = LEN_CHK && (npay != int'(hdr[7:2]));
        push_beat(s, {1'b0, par});
        exp_q.push_back({2'(s), 1'b0, par, e});
    endtask

    task automatic clear_all();
        sq0.delete(); sq1.delete(); sq2.delete(); exp_q.delete();
        err_pend_vld = 0; after_parity = 0; cur_xfers = 0; busy_len = 0;
    endtask

    task automatic monitor();
        logic [2:0] g3, rdy;
        logic [1:0] g;
        beat_t      hb;
        exp_t       e;
        g3  = {bus.grant_2, bus.grant_1, bus.grant_0};
        rdy = {bus.src_ready_2, bus.src_ready_1, bus.src_ready_0};
        chk("grant_onehot", 32'($countones(g3) <= 1), 32'd1);
        if (err_pend_vld) begin
            chk("len_err_pulse", bus.arb_len_err, err_pend);
            err_pend_vld = 0;
        end else begin
            chk("len_err_quiet", bus.arb_len_err, 1'b0);
        end
        if (bus.arb_len_err === 1'b1) err_seen++;
        if (g3 == 3'b000) begin
            chk("idle_data", bus.data_in, 8'h00);
            chk("idle_pkt_valid", bus.pkt_valid, 1'b0);
            chk("idle_ready", rdy, 3'b000);
            if (after_parity) gap_run++;
        end else begin
            g = g3[1] ? 2'd1 : (g3[2] ? 2'd2 : 2'd0);
            if (after_parity) begin
                gap_log.push_back(gap_run);
                after_parity = 0;
            end
            hb = head(int'(g));
            chk("mux_data", bus.data_in, hb.d);
            chk("mux_valid", bus.pkt_valid, hb.v);
            chk("ready", rdy, bus.busy ? 3'b000 : g3);
            if (bus.busy) stall_cnt++;
            if (rdy != 3'b000) begin
                pop_beat(int'(g));
                cur_xfers++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_extra actual=%0h required=none", bus.data_in);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_src", g, e.s);
                    chk("sb_data", bus.data_in, e.d);
                    chk("sb_valid", bus.pkt_valid, e.v);
                    if (!e.v) begin
                        err_pend_vld = 1; err_pend = e.e;
                        cur_xfers = 0; after_parity = 1; gap_run = 0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        beat_t b;
        @(negedge clock);
        bus.busy = (busy_len > 0) && (cur_xfers == busy_at);
        if (bus.busy) busy_len--;
        b = head(0); bus.src_valid_0 = b.v; bus.src_data_0 = b.d;
        b = head(1); bus.src_valid_1 = b.v; bus.src_data_1 = b.d;
        b = head(2); bus.src_valid_2 = b.v; bus.src_data_2 = b.d;
        #1;
        monitor();
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || {bus.grant_2, bus.grant_1, bus.grant_0} != 3'b000) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d left required=0", exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_all();
        repeat (2) step();
        resetn = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 8'h0C, 3,  8'h01, 8'h0E, 0, 0, 0,          0};
        vecs[1] = '{1, 8'h10, 4,  8'h21, 8'h5A, 2, 3, 0,          3};
        vecs[2] = '{0, 8'h08, 3,  8'h31, 8'h3C, 0, 0, int'(LEN_CHK), 0};
        vecs[3] = '{2, 8'h00, 0,  8'h00, 8'h77, 0, 0, 0,          0};
        vecs[4] = '{1, 8'hFC, 62, 8'h80, 8'hC3, 5, 1, int'(LEN_CHK), 1};
        vecs[5] = '{2, 8'h05, 1,  8'h44, 8'h99, 2, 2, 0,          2};

        bus.busy = 1'b0;
        bus.src_valid_0 = 1'b0; bus.src_valid_1 = 1'b0; bus.src_valid_2 = 1'b0;
        bus.src_data_0 = 8'h00; bus.src_data_1 = 8'h00; bus.src_data_2 = 8'h00;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_grant", {bus.grant_2, bus.grant_1, bus.grant_0}, 3'b000);
        chk("rst_ready", {bus.src_ready_2, bus.src_ready_1, bus.src_ready_0}, 3'b000);
        chk("rst_pkt_valid", bus.pkt_valid, 1'b0);
        chk("rst_data_in", bus.data_in, 8'h00);
        chk("rst_len_err", bus.arb_len_err, 1'b0);
        do_reset();

        // Single-packet vectors: data path, busy stalls, length check.
        for (int v = 0; v < 6; v++) begin
            stall_cnt = 0; err_seen = 0;
            busy_at = vecs[v].b_at; busy_len = vecs[v].b_len;
            load_pkt(vecs[v].s, vecs[v].hdr, vecs[v].npay, vecs[v].pbase, vecs[v].par);
            run_idle(200);
            chk("vec_stall", stall_cnt, vecs[v].exp_stall);
            chk("vec_err_count", err_seen, vecs[v].exp_err);
            chk("vec_src_drained", sq0.size() + sq1.size() + sq2.size(), 0);
        end

        // All three request together after reset: order 0,1,2, two idle samples between packets.
        do_reset();
        gap_log.delete();
        load_pkt(0, 8'h08, 2, 8'h10, 8'hA0);
        load_pkt(1, 8'h08, 2, 8'h20, 8'hA1);
        load_pkt(2, 8'h08, 2, 8'h30, 8'hA2);
        run_idle(100);
        chk("gap_count", gap_log.size(), 2);
        if (gap_log.size() == 2) begin
            chk("gap_0_1", gap_log[0], 2);
            chk("gap_1_2", gap_log[1], 2);
        end
        // ptr wrapped to 0: with 0 and 2 requesting, 0 goes first.
        load_pkt(0, 8'h04, 1, 8'h40, 8'hB0);
        load_pkt(2, 8'h04, 1, 8'h50, 8'hB2);
        run_idle(100);

        // Source 2 finishing while 2 and 0 request: 0 must come next.
        load_pkt(2, 8'h08, 2, 8'h60, 8'hC2);
        repeat (2) step();
        load_pkt(0, 8'h08, 2, 8'h70, 8'hC0);
        load_pkt(2, 8'h08, 2, 8'h78, 8'hC4);
        run_idle(100);

        // Reset in the middle of a source-2 payload.
        err_seen = 0;
        load_pkt(2, 8'h18, 6, 8'h90, 8'hD2);
        for (int n = 0; n < 20 && cur_xfers < 3; n++) step();
        chk("mid_pkt_grant2_before", bus.grant_2, 1'b1);
        load_pkt(0, 8'h04, 1, 8'hE0, 8'hD0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_grant_2", bus.grant_2, 1'b0);
        chk("arst_pkt_valid", bus.pkt_valid, 1'b0);
        chk("arst_src_ready_2", bus.src_ready_2, 1'b0);
        chk("arst_data_in", bus.data_in, 8'h00);
        clear_all();
        load_pkt(0, 8'h04, 1, 8'hE0, 8'hD0);
        load_pkt(2, 8'h18, 6, 8'h90, 8'hD2);
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_grant_0", bus.grant_0, 1'b1);
        run_idle(100);
        chk("post_rst_err_count", err_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/router_in_arb.md
ROUTER_IN_ARB -- requirements
Module: router_in_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock and resetn.
REQ-002 Ports SHALL be, one per line:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- src_valid_0/1/2  in  1 each  source N driving header/payload (low on parity byte)
- src_data_0/1/2  in  8 each  source N byte (header, payload or parity)
- src_ready_0/1/2  out  1 each  source N byte accepted at this rising edge
- grant_0/1/2  out  1 each  registered one-hot grant; all low when no grant
- busy  in  1  router input stall
- data_in  out  8  byte to router input
- pkt_valid  out  1  packet valid to router
- arb_len_err  out  1  one-cycle length-mismatch pulse

Function
REQ-003 The block SHALL share the single router input between three packet sources, one whole packet at a time.
REQ-004 The FSM SHALL have states IDLE, PASS, GAP.
REQ-005 IDLE: if any src_valid_N high, SHALL latch grant to the first requester at or after pointer ptr (order ptr, ptr+1, ptr+2 mod 3) and go to PASS next cycle; otherwise stay in IDLE.
REQ-006 PASS: data_in SHALL equal src_data_g and pkt_valid SHALL equal src_valid_g (combinational mux of granted source g).
REQ-007 PASS: src_ready_g SHALL be high exactly when busy is low; all non-granted src_ready SHALL be low.
REQ-008 A byte SHALL transfer on each rising edge with PASS and src_ready_g high; with src_valid_g high it is header (first) or payload.
REQ-009 The first transfer with src_valid_g low SHALL be the parity byte; after it the FSM SHALL go to GAP, set ptr to (g+1) mod 3, and clear grant.
REQ-010 GAP SHALL last exactly one cycle, then IDLE; a new grant SHALL therefore take effect no earlier than two cycles after parity transfer.
REQ-011 In IDLE and GAP, data_in SHALL be 8'h00, pkt_valid 0, all src_ready 0.
REQ-012 While busy is high in PASS, the FSM SHALL hold state, grant and counters; no transfer occurs.
REQ-013 Sources requesting during PASS or GAP SHALL wait; requests are never dropped, only deferred.
REQ-014 A 6-bit transfer counter SHALL count valid transfers of the current packet; it SHALL be cleared on entry to PASS.

Reset
REQ-015 resetn low SHALL immediately force: state IDLE, ptr 0, all grant 0, all src_ready 0, pkt_valid 0, data_in 8'h00, arb_len_err 0, counter 0.
REQ-016 Reset mid-packet SHALL abandon the packet; no GAP cycle, no error pulse; after release, arbitration restarts from source 0.

Configuration
REQ-017 Macro ROUTER_ARB_LEN_CHECK_EN SHALL select length checking.
REQ-018 With it defined: on parity transfer, if valid-transfer count != 1 + header[7:2] (header = first transferred byte), arb_len_err SHALL pulse high for exactly the cycle after the parity edge; counter saturates at 63.
REQ-019 Without it: counter SHALL not exist and arb_len_err SHALL be tied 0; all other behaviour identical.

Verification
REQ-020 Bench SHALL cover:
- Source 0 alone, header 8'h0C (len 3, addr 0), payload 01,02,03, parity 0E, busy 0 -> data_in 0C,01,02,03,0E; pkt_valid 1,1,1,1,0; GAP then IDLE; no error.
- All three request in the same cycle after reset -> packets forwarded in order 0,1,2 with one GAP cycle between; ptr ends at 0.
- busy high 3 cycles in the middle of a source-1 payload -> src_ready_1 low 3 cycles, data_in holds the byte, no lost or duplicated byte.
- (ROUTER_ARB_LEN_CHECK_EN) header 8'h08 (len 2) with 3 payload bytes -> arb_len_err single pulse after parity; without macro -> stays 0.
- resetn low during source-2 payload -> grant_2, pkt_valid, src_ready_2 drop at once; after release, pending source 0 and 2 requests -> source 0 granted first.
- Source 2 finishes while source 2 and 0 request -> source 0 granted next (round-robin, no back-to-back 2).
